// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: system widths,
// funct3 access encodings, FSM states and the alignment rule.
package mem_stage_lsu_pkg;

    localparam int SYS_DATA_WIDTH     = 32;
    localparam int SYS_ADDR_WIDTH     = 32;
    localparam int SYS_TIMEOUT_CYCLES = 255;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Halves must sit on even bytes, words on word boundaries; bytes and
    // reserved load encodings are never rejected.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SH:   mis = offset[0];
                F3_SW:   mis = (offset != 2'b00);
                default: mis = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_LH, F3_LHU: mis = offset[0];
                F3_LW:         mis = (offset != 2'b00);
                default:       mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Single-outstanding request/response data bus between the LSU (master)
// and the data memory or interconnect (slave).
interface mem_stage_lsu_if
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = SYS_ADDR_WIDTH,
    parameter int DATA_WIDTH = SYS_DATA_WIDTH
);
    logic                  dbus_req;
    logic                  dbus_we;
    logic [ADDR_WIDTH-1:0] dbus_addr;
    logic [DATA_WIDTH-1:0] dbus_wdata;
    logic [3:0]            dbus_wstrb;
    logic                  dbus_ready;
    logic                  dbus_rvalid;
    logic [DATA_WIDTH-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ready, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ready, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// Picks the addressed byte/half out of a raw bus word and sign- or
// zero-extends it according to funct3. Reserved encodings pass the word.
module mem_stage_lsu_load_extend
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]                funct3,
    input  logic [1:0]                offset,
    input  logic [SYS_DATA_WIDTH-1:0] raw,
    output logic [SYS_DATA_WIDTH-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension.
    always_comb begin
        byte_sel = raw[7:0];
        case (offset)
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            2'd3:    byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = offset[1] ? raw[31:16] : raw[15:0];

        case (funct3)
            F3_LB:   data = {{(SYS_DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(SYS_DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(SYS_DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(SYS_DATA_WIDTH-16){1'b0}}, half_sel};
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one bus access per load/store, stalls
// the pipeline until it completes, extends load data and reports misaligned
// accesses and bus timeouts as one-cycle pulses in DONE.
//
// state | meaning
// IDLE  | evaluate the instruction held in EX/MEM; stall if it accesses memory
// REQ   | dbus_req high, bus fields frozen until dbus_ready or timeout
// RESP  | read accepted, waiting for dbus_rvalid or timeout
// DONE  | stall released for one cycle; error pulses and new load_data visible
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = SYS_DATA_WIDTH,
    parameter int BUS_ADDR_WIDTH = SYS_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = SYS_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_r,
    input  logic                      mem_w,
    input  logic [BUS_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [3:0]                mem_wstrb,
    input  logic [2:0]                mem_funct3,
    output logic                      mem_stall,
    output logic [DATA_WIDTH-1:0]     load_data,
    output logic                      misalign_err,
    output logic                      bus_err,
    mem_stage_lsu_if.master           dbus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t state, state_nxt;

    logic [CW-1:0]             tmo_cnt;
    logic                      tmo_hit;
    logic                      access;
    logic                      access_mis;
    logic                      set_mis;
    logic                      set_berr;
    logic                      capture;
    logic                      req_we;
    logic [BUS_ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [3:0]                req_wstrb;
    logic [2:0]                req_funct3;
    logic [1:0]                req_off;
    logic [DATA_WIDTH-1:0]     ext_data;

    assign access     = mem_r | mem_w;
    assign access_mis = is_misaligned(mem_w, mem_funct3, mem_addr[1:0]);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);

    assign dbus.dbus_req   = (state == ST_REQ);
    assign dbus.dbus_we    = req_we;
    assign dbus.dbus_addr  = req_addr;
    assign dbus.dbus_wdata = req_wdata;
    assign dbus.dbus_wstrb = req_wstrb;

    mem_stage_lsu_load_extend u_load_extend (
        .funct3 (req_funct3),
        .offset (req_off),
        .raw    (dbus.dbus_rdata),
        .data   (ext_data)
    );

    // Next state, stall and the completion events that feed the registers.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        set_mis   = 1'b0;
        set_berr  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    mem_stall = 1'b1;
                    if (access_mis) begin
                        set_mis   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                if (dbus.dbus_ready) begin
                    if (req_we) begin
                        state_nxt = ST_DONE;
                    end else if (dbus.dbus_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end else if (tmo_hit) begin
                    set_berr  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_RESP: begin
                mem_stall = 1'b1;
                if (dbus.dbus_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tmo_hit) begin
                    set_berr  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Wait-cycle counter, restarted whenever REQ or RESP is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state_nxt != state) &&
                     ((state_nxt == ST_REQ) || (state_nxt == ST_RESP))) begin
            tmo_cnt <= '0;
        end else if ((state == ST_REQ) || (state == ST_RESP)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Bus fields are captured once in IDLE and held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= '0;
            req_funct3 <= '0;
            req_off    <= '0;
        end else if ((state == ST_IDLE) && access && !access_mis) begin
            req_we     <= mem_w;
            req_addr   <= {mem_addr[BUS_ADDR_WIDTH-1:2], 2'b00};
            req_wdata  <= mem_w ? mem_wdata : '0;
            req_wstrb  <= mem_w ? mem_wstrb : 4'h0;
            req_funct3 <= mem_funct3;
            req_off    <= mem_addr[1:0];
        end
    end

    // Error pulses land exactly on the DONE cycle; failed loads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            load_data    <= '0;
        end else begin
            misalign_err <= set_mis;
            bus_err      <= set_berr;
            if (capture)
                load_data <= ext_data;
            else if ((set_mis && !mem_w) || (set_berr && !req_we))
                load_data <= '0;
        end
    end
endmodule
